// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by both the transmit and receive sides.
package uart_pkg;

  // Frame sequencing states shared by the serializer FSMs.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 8N1 framing.
  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_STOP_BITS  = 1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per bit period.
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/rs232_tx_buf_if.sv
// Producer-facing bundle of the buffered RS232 transmitter.
//
// Handshake: pi_flag is the valid strobe and ~fifo_full is the ready. A byte
// transfers on a rising edge where pi_flag=1 and fifo_full=0. The producer never
// holds pi_flag waiting for ready: a strobe seen while fifo_full=1 is dropped and
// answered with a one-cycle ovf_flag pulse. pi_data is only looked at on a
// transferring edge.
interface rs232_tx_buf_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       tx;
  logic       fifo_full;
  logic       tx_busy;
  logic       ovf_flag;

  modport master (
    output pi_data, pi_flag,
    input  tx, fifo_full, tx_busy, ovf_flag
  );

  modport slave (
    input  pi_data, pi_flag,
    output tx, fifo_full, tx_busy, ovf_flag
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Pointers and count carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, count, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Qualify requests against the registered flags only.
  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && !empty_q;
    count_d = count;
    if (do_push && !do_pop) count_d = count + 1'b1;
    else if (do_pop && !do_push) count_d = count - 1'b1;
  end

  // Storage array; written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/rs232_tx_buf.sv
// Buffered 8N1 RS232 transmitter: queues producer bytes in a FIFO and sends
// them LSB first, back-to-back, on a registered tx line.
module rs232_tx_buf
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  rs232_tx_buf_if.slave bus,
  output uart_state_t dbg_state
);
  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int BCW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT_MAX - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_t    state_q, state_d;
  logic [BCW-1:0] baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy_q, ovf_q;
  logic           pop, fifo_empty, fifo_full, baud_end;
  logic [7:0]     pop_data;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (bus.pi_flag),
    .push_data (bus.pi_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, pop request and next line level; the baud counter restarts on
  // every state entry so each bit is exactly one full baud period.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = pop_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = pop_data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE || state_d != state_q || baud_end) baud_d = '0;
    else baud_d = baud_q + 1'b1;
  end

  // State, counters, shifter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      ovf_q   <= bus.pi_flag && fifo_full;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.fifo_full = fifo_full;
  assign bus.tx_busy   = busy_q;
  assign bus.ovf_flag  = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rs232_tx_buf.sv
// Bench for rs232_tx_buf: random and directed pushes, a frame-timing reference
// model, and a line decoder that scores each received frame.
module tb_rs232_tx_buf;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 800;
  localparam int UART_BPS   = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CYC    = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYC  = 10 * BIT_CYC;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  uart_state_t dbg_state;
  int          cyc = 0;

  rs232_tx_buf_if bus();

  rs232_tx_buf #(
    .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  int         exp_start_q[$];
  int         exp_ovf_q[$];
  int         acc_start[$];
  int         last_start = -1000;
  int         errors = 0;
  int         checks = 0;
  bit         busy_chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO occupancy seen at edge c = accepted bytes whose frame has not started
  // by edge c-1.
  function automatic bit model_full(input int c);
    int n = 0;
    foreach (acc_start[i]) if (acc_start[i] > c - 1) n++;
    return n >= FIFO_DEPTH;
  endfunction

  // Busy after edge n iff some frame spans edge n.
  function automatic bit model_busy(input int n);
    foreach (acc_start[i])
      if (acc_start[i] <= n && n < acc_start[i] + FRAME_CYC) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    acc_start.delete();
    exp_q.delete();
    exp_start_q.delete();
    exp_ovf_q.delete();
    last_start = -1000;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    int c, s;
    bit full_exp;
    @(negedge sys_clk);
    c = cyc + 1;
    full_exp = model_full(c);
    check("fifo_full", int'(bus.fifo_full), int'(full_exp));
    bus.pi_data = b;
    bus.pi_flag = 1'b1;
    if (!full_exp) begin
      s = (c + 1 > last_start + FRAME_CYC) ? c + 1 : last_start + FRAME_CYC;
      acc_start.push_back(s);
      last_start = s;
      exp_q.push_back(b);
      exp_start_q.push_back(s);
    end else begin
      exp_ovf_q.push_back(c);
    end
  endtask

  task automatic release_line();
    @(negedge sys_clk);
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'($urandom);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge sys_clk);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((cyc <= last_start + FRAME_CYC + 2 || exp_q.size() != 0) && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    check("drain_exp_empty", exp_q.size(), 0);
  endtask

  task automatic idle_line_check(input int n);
    bit low_seen = 0;
    repeat (n) begin
      @(negedge sys_clk);
      if (bus.tx !== 1'b1) low_seen = 1;
    end
    check("tx_idle_high", int'(low_seen), 0);
  endtask

  // ---------------- monitors ----------------
  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = '0;

  // Line decoder: samples each bit mid-period and scores the completed frame.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (bus.tx == 1'b0) begin
        mon_active = 1;
        mon_cnt    = 0;
        mon_start  = cyc;
        mon_byte   = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == BIT_CYC / 2) begin
        check("start_bit", int'(bus.tx), 0);
      end else if (mon_cnt >= BIT_CYC + BIT_CYC / 2 && mon_cnt < 9 * BIT_CYC &&
                   (mon_cnt % BIT_CYC) == BIT_CYC / 2) begin
        mon_byte[3'((mon_cnt - BIT_CYC) / BIT_CYC)] = bus.tx;
      end else if (mon_cnt == 9 * BIT_CYC + BIT_CYC / 2) begin
        check("stop_bit", int'(bus.tx), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", int'(mon_byte), -1);
        end else begin
          check("rx_byte", int'(mon_byte), int'(exp_q.pop_front()));
          check("frame_start_cycle", mon_start, exp_start_q.pop_front());
        end
        mon_active = 0;
      end
    end
  end

  // Overflow pulse checker.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (exp_ovf_q.size() > 0 && exp_ovf_q[0] == cyc) begin
        check("ovf_pulse", int'(bus.ovf_flag), 1);
        void'(exp_ovf_q.pop_front());
      end else if (bus.ovf_flag) begin
        check("ovf_spurious", int'(bus.ovf_flag), 0);
      end
    end
  end

  // Per-cycle busy check against the frame-span model.
  always @(negedge sys_clk) begin
    if (sys_rst_n && busy_chk_en)
      check("tx_busy", int'(bus.tx_busy), int'(model_busy(cyc)));
  end

  // Watchdog.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e, s, n, gap;
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    sys_rst_n   = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx", int'(bus.tx), 1);
    check("rst_busy", int'(bus.tx_busy), 0);
    check("rst_full", int'(bus.fifo_full), 0);
    check("rst_ovf", int'(bus.ovf_flag), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    sys_rst_n   = 1'b1;
    busy_chk_en = 1;
    idle_line_check(100);

    // Single byte with explicit busy fall at E+81
    push_byte(8'hA5);
    e = last_start - 1;
    release_line();
    wait_until(e + 80);
    check("busy_before_fall", int'(bus.tx_busy), 1);
    wait_until(e + 81);
    check("busy_fall", int'(bus.tx_busy), 0);
    wait_drain(1000);

    // Back-to-back
    push_byte(8'h55);
    push_byte(8'h0F);
    release_line();
    wait_drain(1000);

    // Overflow: 01 pops at once, 02..05 fill, 06 dropped
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    release_line();
    check("ovf_model_drop", exp_q.size(), 5);
    wait_drain(2000);

    // Push during STOP of the last queued byte
    push_byte(8'h3C);
    release_line();
    s = last_start;
    wait_until(s + 9 * BIT_CYC + 2);
    push_byte(8'hC3);
    release_line();
    check("stop_push_no_gap", last_start - s, FRAME_CYC);
    wait_drain(1000);

    // Random bursts with random gaps
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) push_byte(8'($urandom));
      release_line();
      gap = $urandom_range(0, 120);
      repeat (gap) @(negedge sys_clk);
    end
    wait_drain(4000);

    // Mid-frame reset during data bit 3 of 8'hFF
    push_byte(8'hFF);
    release_line();
    s = last_start;
    wait_until(s + 4 * BIT_CYC + BIT_CYC / 2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(bus.tx), 1);
    check("midrst_busy", int'(bus.tx_busy), 0);
    check("midrst_full", int'(bus.fifo_full), 0);
    model_clear();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_line_check(100);
    check("postrst_busy", int'(bus.tx_busy), 0);
    check("postrst_state", int'(dbg_state), int'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
